// File: rtl/kl8e_tx.sv
// KL8E teleprinter transmitter: IOT-driven 8N1 async serializer with printer flag and IRQ.
// Optional even-parity bit between data and stop when KL8E_TX_PARITY_EN is defined.
module kl8e_tx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tpc,
  input  logic       tls,
  input  logic       tcf,
  input  logic       kie,
  input  logic       kie_data,
  input  logic [0:7] data,
  output logic       tx,
  output logic       flag,
  output logic       busy,
  output logic       irq
);

  // DIV must be at least 2 for the baud counter to be meaningful.
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef KL8E_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [0:7]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            flag_q, flag_d;
  logic            ie_q, ie_d;
  logic            done;
  logic            baud_end;
`ifdef KL8E_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign baud_end = (baud_q == LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done    = 1'b0;
`ifdef KL8E_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tpc || tls) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = data;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef KL8E_TX_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          tx_d    = shift_q[7];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef KL8E_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // LSB (data[7]) goes first; shift toward index 7.
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[0:6]};
            tx_d    = shift_q[6];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef KL8E_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          state_d = S_IDLE;
          baud_d  = '0;
          busy_d  = 1'b0;
          done    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Frame completion beats a same-cycle clear.
  assign flag_d = done | (flag_q & ~(tcf | tls));
  assign ie_d   = kie ? kie_data : ie_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
      ie_q    <= 1'b1;
`ifdef KL8E_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      flag_q  <= flag_d;
      ie_q    <= ie_d;
`ifdef KL8E_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign flag = flag_q;
  assign busy = busy_q;
  assign irq  = flag_q & ie_q;

endmodule

// File: tb/tb_kl8e_tx.sv
// Bench for kl8e_tx: per-cycle {busy,tx} scoreboard, loopback receiver model, flag/irq scenarios.
// Honors KL8E_TX_PARITY_EN to expect the parity bit.
module tb_kl8e_tx;
  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       reset, tpc, tls, tcf, kie, kie_data;
  logic [0:7] data;
  logic       tx, flag, busy, irq;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  logic [1:0] e;
  logic [7:0] got_b;
  logic [7:0] want_b;

  kl8e_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk(clk), .reset(reset), .tpc(tpc), .tls(tls), .tcf(tcf),
    .kie(kie), .kie_data(kie_data), .data(data),
    .tx(tx), .flag(flag), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: one expected {busy,tx} per cycle, compared at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, tx} !== e) begin
        errors++;
        $display("FAIL frame_wave at %0t: got busy=%b tx=%b expected busy=%b tx=%b",
                 $time, busy, tx, e[1], e[0]);
      end
    end
  end

  // Loopback receiver: mid-bit sampling, LSB first.
  initial forever begin
    @(negedge clk);
    if (tx === 1'b0) begin
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        rx_byte[i] = tx;
      end
`ifdef KL8E_TX_PARITY_EN
      repeat (DIV) @(negedge clk);
`endif
      repeat (DIV) @(negedge clk);
      if (tx === 1'b1) rx_q.push_back(rx_byte);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1: strobe is high for exactly one cycle.
  task automatic strobe(input logic s_tls, input logic s_tpc, input logic s_tcf, input logic [0:7] d);
    tls = s_tls; tpc = s_tpc; tcf = s_tcf; data = d;
    @(posedge clk);
    #1;
    tls = 1'b0; tpc = 1'b0; tcf = 1'b0;
  endtask

  task automatic push_frame(input logic [0:7] d);
    for (int c = 0; c < DIV; c++) exp_q.push_back(2'b10);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < DIV; c++) exp_q.push_back({1'b1, d[7-i]});
`ifdef KL8E_TX_PARITY_EN
    for (int c = 0; c < DIV; c++) exp_q.push_back({1'b1, ^d});
`endif
    for (int c = 0; c < DIV; c++) exp_q.push_back(2'b11);
  endtask

  task automatic wait_done;
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, flag, busy, irq} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_idle: got tx=%b flag=%b busy=%b irq=%b expected 1 0 0 0", tx, flag, busy, irq);
      end
    end
  endtask

  task automatic test_frame;
    rx_q.delete();
    step(1);
    strobe(1'b1, 1'b0, 1'b0, 8'h41);
    push_frame(8'h41);
    wait_done();
    @(negedge clk);
    checks++;
    if ({tx, flag, busy, irq} !== 4'b1101) begin
      errors++;
      $display("FAIL frame_end: got tx=%b flag=%b busy=%b irq=%b expected 1 1 0 1", tx, flag, busy, irq);
    end
    checks++;
    got_b = (rx_q.size() == 1) ? rx_q[0] : 8'hxx;
    if (got_b !== 8'h41) begin
      errors++;
      $display("FAIL loopback_41: got %h (count %0d) expected 41", got_b, rx_q.size());
    end
  endtask

  task automatic test_load_while_busy;
    rx_q.delete();
    step(1);
    strobe(1'b1, 1'b0, 1'b0, 8'h41);
    push_frame(8'h41);
    @(negedge clk);
    checks++;
    if (flag !== 1'b0) begin
      errors++;
      $display("FAIL tls_clears_flag: got %b expected 0", flag);
    end
    step(39);
    strobe(1'b0, 1'b1, 1'b0, 8'hFF);
    wait_done();
    @(negedge clk);
    checks++;
    if ({flag, busy} !== 2'b10) begin
      errors++;
      $display("FAIL busy_drop_end: got flag=%b busy=%b expected 1 0", flag, busy);
    end
    checks++;
    got_b = (rx_q.size() == 1) ? rx_q[0] : 8'hxx;
    if (got_b !== 8'h41) begin
      errors++;
      $display("FAIL busy_drop_rx: got %h (count %0d) expected 41", got_b, rx_q.size());
    end
  endtask

  task automatic test_flag_irq;
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got %b expected 1", irq);
    end
    @(posedge clk); #1;
    kie = 1'b1; kie_data = 1'b0;
    step(1);
    kie = 1'b0;
    @(negedge clk);
    checks++;
    if ({irq, flag} !== 2'b01) begin
      errors++;
      $display("FAIL kie_off: got irq=%b flag=%b expected 0 1", irq, flag);
    end
    step(1);
    kie = 1'b1; kie_data = 1'b1;
    step(1);
    kie = 1'b0;
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL kie_on: got irq=%b expected 1", irq);
    end
    step(1);
    strobe(1'b0, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    checks++;
    if ({flag, irq} !== 2'b00) begin
      errors++;
      $display("FAIL tcf_clear: got flag=%b irq=%b expected 0 0", flag, irq);
    end
    // tcf landing on the completion cycle: set must win.
    rx_q.delete();
    step(1);
    strobe(1'b0, 1'b1, 1'b0, 8'h00);
    push_frame(8'h00);
    step(159);
    strobe(1'b0, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    checks++;
    if ({flag, busy, tx} !== 3'b101) begin
      errors++;
      $display("FAIL tcf_at_done: got flag=%b busy=%b tx=%b expected 1 0 1", flag, busy, tx);
    end
    checks++;
    got_b = (rx_q.size() == 1) ? rx_q[0] : 8'hxx;
    if (got_b !== 8'h00) begin
      errors++;
      $display("FAIL tcf_at_done_rx: got %h expected 00", got_b);
    end
  endtask

  task automatic test_back_to_back;
    rx_q.delete();
    step(1);
    strobe(1'b1, 1'b0, 1'b0, 8'hA5);
    push_frame(8'hA5);
    step(159);
    // tls on the completion cycle is a load while busy: dropped, set still wins.
    strobe(1'b1, 1'b0, 1'b0, 8'h0F);
    @(negedge clk);
    checks++;
    if ({flag, busy, tx} !== 3'b101) begin
      errors++;
      $display("FAIL tls_at_done: got flag=%b busy=%b tx=%b expected 1 0 1", flag, busy, tx);
    end
    step(1);
    strobe(1'b0, 1'b1, 1'b0, 8'h3C);
    push_frame(8'h3C);
    @(negedge clk);
    checks++;
    if (flag !== 1'b1) begin
      errors++;
      $display("FAIL tpc_keeps_flag: got %b expected 1", flag);
    end
    wait_done();
    @(negedge clk);
    checks++;
    if ({flag, busy} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_end: got flag=%b busy=%b expected 1 0", flag, busy);
    end
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_rx: got count %0d expected A5 then 3C only", rx_q.size());
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      rx_q.delete();
      want_b = 8'($urandom_range(0, 255));
      step($urandom_range(1, 6));
      strobe(1'b1, 1'b0, 1'b0, want_b);
      push_frame(want_b);
      wait_done();
      @(negedge clk);
      checks++;
      got_b = (rx_q.size() == 1) ? rx_q[0] : 8'hxx;
      if (got_b !== want_b || flag !== 1'b1) begin
        errors++;
        $display("FAIL random_rx: got %h flag=%b expected %h flag=1", got_b, flag, want_b);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    step(1);
    kie = 1'b1; kie_data = 1'b0;
    step(1);
    kie = 1'b0;
    strobe(1'b1, 1'b0, 1'b0, 8'h5A);
    push_frame(8'h5A);
    step(69);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({tx, busy, flag, irq} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset: got tx=%b busy=%b flag=%b irq=%b expected 1 0 0 0", tx, busy, flag, irq);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, flag} !== 3'b100) begin
        errors++;
        $display("FAIL post_reset_idle: got tx=%b busy=%b flag=%b expected 1 0 0", tx, busy, flag);
      end
    end
    step(140);
    rx_q.delete();
    strobe(1'b1, 1'b0, 1'b0, 8'hC3);
    push_frame(8'hC3);
    wait_done();
    @(negedge clk);
    checks++;
    if ({flag, busy, irq} !== 3'b101) begin
      errors++;
      $display("FAIL clean_after_reset: got flag=%b busy=%b irq=%b expected 1 0 1", flag, busy, irq);
    end
    checks++;
    got_b = (rx_q.size() == 1) ? rx_q[0] : 8'hxx;
    if (got_b !== 8'hC3) begin
      errors++;
      $display("FAIL clean_rx: got %h expected c3", got_b);
    end
  endtask

  initial begin
    reset = 1'b1; tpc = 1'b0; tls = 1'b0; tcf = 1'b0;
    kie = 1'b0; kie_data = 1'b0; data = 8'h00;
    test_reset();
    test_frame();
    test_load_while_busy();
    test_flag_irq();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
